// File: rtl/ysyx_22040750_mul_pkg.sv
// Shared definitions for the EX-stage multiply controller: op encodings,
// controller states and the operand-signedness helper.
package ysyx_22040750_mul_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    KILL = 2'b11
  } mul_state_e;

  // {mul1 signed, mul2 signed}; word ops feed zero-extended halves unsigned
  function automatic logic [1:0] sext_of(input logic [1:0] op, input logic is_word);
    logic [1:0] flag;
    flag = 2'b00;
    if (is_word) begin
      flag = 2'b00;
    end else begin
      case (op)
        OP_MUL, OP_MULH: flag = 2'b11;
        OP_MULHSU:       flag = 2'b10;
        OP_MULHU:        flag = 2'b00;
        default:         flag = 2'b00;
      endcase
    end
    return flag;
  endfunction

endpackage

// File: rtl/ysyx_22040750_mul_res_sel.sv
// Combinational 128->64 result select: low half, high half, or sign-extended
// low word depending on the latched op.
module ysyx_22040750_mul_res_sel
  import ysyx_22040750_mul_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]     op,
  input  logic           is_word,
  input  logic [2*W-1:0] p,
  output logic [W-1:0]   res
);

  // pick the product slice for the op
  always_comb begin
    res = '0;
    if (is_word) begin
      res = {{(W/2){p[W/2-1]}}, p[W/2-1:0]};
    end else begin
      case (op)
        OP_MUL:                       res = p[W-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: res = p[2*W-1:W];
        default:                      res = p[W-1:0];
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22040750_mul_ctrl.sv
// Sequencing controller for the serial Booth multiplier: accepts one op,
// launches the multiplier, captures/selects the result and holds it for WB.
module ysyx_22040750_mul_ctrl
  import ysyx_22040750_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic              is_word,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              mul_valid,
  output logic [XLEN-1:0]   mul1,
  output logic [XLEN-1:0]   mul2,
  output logic [1:0]        sext_flag,
  input  logic              P_valid,
  input  logic [2*XLEN-1:0] P,
  output logic              busy
);

  mul_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             is_word_q, is_word_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  sel_res_s;
  logic             accept_s;
  logic             zero_s;
  logic             mul_valid_s;

  ysyx_22040750_mul_res_sel #(.W(XLEN)) u_res_sel (
    .op      (op_q),
    .is_word (is_word_q),
    .p       (P),
    .res     (sel_res_s)
  );

  assign accept_s = rst & in_valid & ~flush;
  assign zero_s   = (src1 == '0) | (src2 == '0);

  // next-state, launch pulse and result capture
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    is_word_d   = is_word_q;
    result_d    = result_q;
    mul_valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d      = op;
          is_word_d = is_word;
          if (zero_s) begin
            result_d = '0;
            state_d  = DONE;
          end else begin
            mul_valid_s = 1'b1;
            state_d     = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (P_valid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            result_d = sel_res_s;
            state_d  = DONE;
          end
        end else if (flush) begin
          state_d = KILL;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // flush takes priority over a same-cycle consume
        if (flush) begin
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      KILL: begin
        // no abort on the multiplier: drain its product, flush is moot here
        if (P_valid) begin
          state_d = IDLE;
        end else begin
          state_d = KILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // operand and signedness presentation, only meaningful while idle
  always_comb begin
    mul1      = '0;
    mul2      = '0;
    sext_flag = 2'b00;
    if ((state_q == IDLE) && rst) begin
      sext_flag = sext_of(op, is_word);
      if (is_word) begin
        mul1 = {{(XLEN/2){1'b0}}, src1[XLEN/2-1:0]};
        mul2 = {{(XLEN/2){1'b0}}, src2[XLEN/2-1:0]};
      end else begin
        mul1 = src1;
        mul2 = src2;
      end
    end else begin
      mul1      = '0;
      mul2      = '0;
      sext_flag = 2'b00;
    end
  end

  // controller state and held result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      is_word_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      is_word_q <= is_word_d;
      result_q  <= result_d;
    end
  end

  assign mul_valid = mul_valid_s;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040750_mul_ctrl.sv
// Directed bench for the multiply controller with a behavioural multiplier
// whose latency is set per test.
module tb_ysyx_22040750_mul_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic         is_word = 1'b0;
  logic [63:0]  src1 = 64'd0;
  logic [63:0]  src2 = 64'd0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  result;
  logic         mul_valid;
  logic [63:0]  mul1;
  logic [63:0]  mul2;
  logic [1:0]   sext_flag;
  logic         P_valid;
  logic [127:0] P;
  logic         busy;

  int tests = 0;
  int fails = 0;

  int           lat_cfg = 1;
  int           cnt;
  logic [127:0] prod;
  int           launches = 0;

  always #5 clk = ~clk;

  ysyx_22040750_mul_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_word(is_word), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .mul_valid(mul_valid), .mul1(mul1), .mul2(mul2), .sext_flag(sext_flag),
    .P_valid(P_valid), .P(P), .busy(busy)
  );

  function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] s);
    logic [127:0] a128, b128;
    a128 = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
    b128 = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return a128 * b128;
  endfunction

  // behavioural serial multiplier: P_valid lat_cfg cycles after launch
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 0;
      prod <= 128'd0;
    end else if (mul_valid) begin
      cnt      <= lat_cfg;
      prod     <= mul_model(mul1, mul2, sext_flag);
      launches <= launches + 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign P_valid = (cnt == 1);
  assign P       = prod;

  task automatic do_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int lat,
                       output logic [1:0] sx, output logic [63:0] m1, output logic mv,
                       output logic [63:0] res, output int n, output bit to);
    @(negedge clk);
    lat_cfg = lat; op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
    #1;
    sx = sext_flag; m1 = mul1; mv = mul_valid;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    to  = !out_valid;
    res = result;
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mul_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: in_ready=%b out_valid=%b busy=%b mul_valid=%b, want 1 0 0 0",
               in_ready, out_valid, busy, mul_valid);
    end
    tests++;
    if (result !== 64'd0 || mul1 !== 64'd0 || mul2 !== 64'd0 || sext_flag !== 2'b00) begin
      fails++;
      $display("FAIL reset_data: result=%h mul1=%h mul2=%h sext=%b, want zeros",
               result, mul1, mul2, sext_flag);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_mul_mulh();
    logic [1:0] sx; logic [63:0] m1, res; logic mv; int n; bit to;
    do_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 20, sx, m1, mv, res, n, to);
    tests++;
    if (sx !== 2'b11 || mv !== 1'b1) begin
      fails++; $display("FAIL mul_launch: sext=%b mul_valid=%b, want 11 1", sx, mv);
    end
    tests++;
    if (to || res !== 64'h1 || n != 21) begin
      fails++; $display("FAIL mul_result: result=%h lat=%0d, want 1 lat 21", res, n);
    end
    consume();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mul_consume: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    do_op(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 12, sx, m1, mv, res, n, to);
    tests++;
    if (to || res !== 64'h0 || sx !== 2'b11) begin
      fails++; $display("FAIL mulh_result: result=%h sext=%b, want 0 11", res, sx);
    end
    consume();
  endtask

  task automatic test_mulhu_mulhsu();
    logic [1:0] sx; logic [63:0] m1, res; logic mv; int n; bit to;
    do_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 33, sx, m1, mv, res, n, to);
    tests++;
    if (to || res !== 64'hFFFF_FFFF_FFFF_FFFE || n != 34 || sx !== 2'b00) begin
      fails++; $display("FAIL mulhu: result=%h lat=%0d sext=%b, want fffffffffffffffe 34 00", res, n, sx);
    end
    consume();
    do_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10, sx, m1, mv, res, n, to);
    tests++;
    if (to || res !== 64'hFFFF_FFFF_FFFF_FFFF || sx !== 2'b10) begin
      fails++; $display("FAIL mulhsu: result=%h sext=%b, want ffffffffffffffff 10", res, sx);
    end
    consume();
  endtask

  task automatic test_mulw();
    logic [1:0] sx; logic [63:0] m1, res; logic mv; int n; bit to;
    do_op(2'b00, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 17, sx, m1, mv, res, n, to);
    tests++;
    if (m1 !== 64'h0000_0000_7FFF_FFFF || sx !== 2'b00) begin
      fails++; $display("FAIL mulw_operands: mul1=%h sext=%b, want 000000007fffffff 00", m1, sx);
    end
    tests++;
    if (to || res !== 64'hFFFF_FFFF_FFFF_FFFE || n > 18) begin
      fails++; $display("FAIL mulw_result: result=%h lat=%0d, want fffffffffffffffe lat<=18", res, n);
    end
    consume();
  endtask

  task automatic test_zero();
    logic [1:0] sx; logic [63:0] m1, res; logic mv; int n; bit to; int l0;
    l0 = launches;
    do_op(2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5, sx, m1, mv, res, n, to);
    tests++;
    if (to || res !== 64'd0 || n != 1 || mv !== 1'b0 || launches != l0) begin
      fails++; $display("FAIL zero_fast: result=%h lat=%0d mul_valid=%b launches=%0d, want 0 1 0 %0d",
                        res, n, mv, launches, l0);
    end
    consume();
  endtask

  task automatic test_flush_busy();
    logic [1:0] sx; logic [63:0] m1, res; logic mv; int n; bit to; bit bad; int k;
    @(negedge clk);
    lat_cfg = 30; op = 2'b00; is_word = 1'b0; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_kill: busy=%b in_ready=%b out_valid=%b, want 1 0 0", busy, in_ready, out_valid);
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL kill_flush_ignored: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    bad = 1'b0; k = 0;
    while (!P_valid && k < 60) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    tests++;
    if (!P_valid || bad) begin
      fails++; $display("FAIL kill_drain: P_valid=%b early_exit=%b, want 1 0", P_valid, bad);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL kill_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    do_op(2'b00, 1'b0, 64'd6, 64'd7, 3, sx, m1, mv, res, n, to);
    tests++;
    if (to || res !== 64'd42 || n != 4) begin
      fails++; $display("FAIL after_flush: result=%0d lat=%0d, want 42 4", res, n);
    end
    consume();
  endtask

  task automatic test_hold();
    logic [1:0] sx; logic [63:0] m1, res; logic mv; int n; bit to; int l0;
    do_op(2'b00, 1'b0, 64'd3, 64'd5, 2, sx, m1, mv, res, n, to);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (result !== 64'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_%0d: result=%0d out_valid=%b in_ready=%b, want 15 1 0",
                          i, result, out_valid, in_ready);
      end
    end
    l0 = launches;
    in_valid = 1'b1; src1 = 64'd9; src2 = 64'd9;
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || launches != l0) begin
      fails++; $display("FAIL done_flush: out_valid=%b in_ready=%b launches=%0d, want 0 1 %0d",
                        out_valid, in_ready, launches, l0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    lat_cfg = 30; op = 2'b01; is_word = 1'b0; src1 = 64'd11; src2 = 64'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL arst_pre: busy=%b, want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mul_valid !== 1'b0 ||
        result !== 64'd0 || mul1 !== 64'd0 || mul2 !== 64'd0 || sext_flag !== 2'b00) begin
      fails++; $display("FAIL arst: in_ready=%b out_valid=%b busy=%b mul_valid=%b result=%h mul1=%h mul2=%h sext=%b",
                        in_ready, out_valid, busy, mul_valid, result, mul1, mul2, sext_flag);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mul_mulh();
    test_mulhu_mulhsu();
    test_mulw();
    test_zero();
    test_flush_busy();
    test_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_mul_ctrl.md
# ysyx_22040750_mul_ctrl

Sequencing controller for the serial radix-4 Booth multiplier (`ysyx_22040750_booth_mul_serial`) in the EX stage of the full-pipeline core. It accepts one RV64M multiply op at a time from EX through a valid/ready handshake, and derives operands and `sext_flag` from the op. It launches the multiplier, selects and sign-extends the 64-bit result from the 128-bit product, and holds that result until WB-side acceptance. It also handles pipeline flush and a zero-operand fast path.

## Interface
Parameters:
- XLEN, 64, operand/result width; only 64 supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents a multiply op.
- in_ready  out  1  controller can accept this cycle.
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- is_word  in  1  MULW; only legal with op=00.
- src1, src2  in  64  rs1/rs2 values.
- flush  in  1  kill in-flight op; no result is produced for it.
- out_valid  out  1  result held for WB.
- out_ready  in  1  WB consumes the result.
- result  out  64  selected result.
- mul_valid  out  1  one-cycle launch pulse to the multiplier.
- mul1, mul2  out  64  multiplier operands.
- sext_flag  out  2  {mul1 signed, mul2 signed}.
- P_valid  in  1  multiplier product valid (combinational on its side).
- P  in  128  multiplier product.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, BUSY, DONE, KILL.
- IDLE: in_ready=1. Accept = in_valid & ~flush.
  - Accept with src1==0 or src2==0: go to DONE with result=0. mul_valid stays 0.
  - Accept otherwise: mul_valid=1 in the same cycle, then go to BUSY.
- mul1/mul2/sext_flag are combinational from inputs while in IDLE, and 0 elsewhere.
- Operands and sext_flag by op:
  - MUL/MULH: src1, src2, flag 11.
  - MULHSU: flag 10.
  - MULHU: flag 00.
  - is_word: {32'b0,src1[31:0]}, {32'b0,src2[31:0]}, flag 00. The small mul1 gives early termination.
- Registered op/is_word select the result at capture:
  - MUL: P[63:0].
  - MULH/MULHSU/MULHU: P[127:64].
  - MULW: {{32{P[31]}},P[31:0]}.
- BUSY:
  - P_valid: capture result, go to DONE.
  - flush & ~P_valid: go to KILL.
  - flush & P_valid: go to IDLE, discard result.
- DONE: out_valid=1; result is stable.
  - out_ready: go to IDLE.
  - flush: go to IDLE, out_valid drops next cycle. flush wins over out_ready.
- KILL: the multiplier has no abort, so the product is drained.
  - P_valid: go to IDLE, discard.
  - flush in KILL is ignored.
- P_valid is ignored in IDLE and DONE.
- in_ready=0 outside IDLE. No back-to-back acceptance from DONE.

## Timing
- Reset (rst low, async) values:
  - state=IDLE, in_ready=1.
  - out_valid=0, result=0, mul_valid=0, mul1=mul2=0, sext_flag=0, busy=0.
  - Internal op/is_word regs = 0.
- Reset mid-operation aborts at once. The multiplier keeps its own synchronous reset; the parent ties it to ~rst.
- Launch latency, with accept in cycle T:
  - Multiplier P_valid occurs in cycle T+1 … T+33.
  - Result captured on that edge; out_valid rises the next cycle.
  - Accept to out_valid: 2 to 34 cycles. Zero fast path: 1 cycle.
  - MULW worst case is about T+17.
- out_valid/result hold until the out_ready or flush edge.

## Structure
- Shared package `ysyx_22040750_mul_pkg`: op encoding constants (MUL, MULH, MULHSU, MULHU) and the state encoding (IDLE, BUSY, DONE, KILL).
- One natural sub-module: `ysyx_22040750_mul_res_sel`, a combinational 128→64 result select/sign-extend from op/is_word.
- The multiplier is instantiated beside the controller in the EX-stage parent, not inside it.

## Test plan
- MUL and MULH, src1=src2=0xFFFF_FFFF_FFFF_FFFF:
  - MUL result = 0x1.
  - MULH result = 0x0.
  - sext_flag = 11.
- MULHU, both operands 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE, out_valid exactly 34 cycles after accept. MULHSU with the same operands → 0xFFFF_FFFF_FFFF_FFFF, sext_flag = 10.
- MULW, src1=0x7FFF_FFFF, src2=2 → 0xFFFF_FFFF_FFFF_FFFE. mul1 upper 32 bits = 0; out_valid at or before accept+18.
- src2=0, op=MULH → out_valid the cycle after accept, result=0, mul_valid never asserted.
- Flush in BUSY, 5 cycles after accepting MUL 3×5 → KILL, no out_valid. in_ready returns the cycle after P_valid. A following MUL 6×7 yields 42.
- out_ready held low 10 cycles in DONE → result stable, in_ready=0. Async rst asserted while BUSY → all outputs at reset values before the next clk edge.
